// File: rtl/issue_select.sv
// issue_select: in-order dual-issue select stage with a physical-register busy scoreboard.
// Define ISSUE_WB_BYPASS_EN to let a writeback wake dependents in the same cycle.
package issue_select_pkg;
    localparam int PREG_WIDTH = 6;
    localparam int IQ_ADDR    = 5;

    typedef struct packed {
        logic [7:0]            tag;
        logic [PREG_WIDTH-1:0] src1;
        logic [PREG_WIDTH-1:0] src2;
        logic [PREG_WIDTH-1:0] dst;
        logic                  src1_en;
        logic                  src2_en;
        logic                  dst_en;
    } issue_queue_element_t;
endpackage

module issue_select
    import issue_select_pkg::*;
#(
    parameter int PREG_W = PREG_WIDTH,
    parameter int NUM_WB = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [IQ_ADDR-1:0]               q_size,
    input  issue_queue_element_t [1:0]       q_data,
    output logic [1:0]                       out_data_number,
    input  logic [NUM_WB-1:0]                wb_valid,
    input  logic [NUM_WB-1:0][PREG_W-1:0]    wb_preg,
    input  logic [1:0]                       fu_ready,
    output logic [1:0]                       iss_valid,
    output issue_queue_element_t [1:0]       iss_data
);

    localparam int NPREG = 1 << PREG_W;

    logic [NPREG-1:0]           busy_q;
    logic [NPREG-1:0]           busy_d;
    logic [NPREG-1:0]           wake;
    logic [NPREG-1:0]           blocked;
    logic [1:0]                 iss_valid_q;
    issue_queue_element_t [1:0] iss_data_q;
    logic [1:0]                 issue;
    logic [1:0]                 slot_free;
    logic                       src_ok0;
    logic                       src_ok1;
    logic                       raw;

`ifdef ISSUE_WB_BYPASS_EN
    always_comb begin
        wake = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k]) begin
                wake[wb_preg[k]] = 1'b1;
            end
        end
    end
`else
    assign wake = '0;
`endif

    assign blocked = busy_q & ~wake;

    function automatic logic src_rdy(
        input logic              en,
        input logic [PREG_W-1:0] p,
        input logic [NPREG-1:0]  blk
    );
        return !en || (p == '0) || !blk[p];
    endfunction

    assign slot_free = ~iss_valid_q | fu_ready;

    assign src_ok0 = src_rdy(q_data[0].src1_en, q_data[0].src1, blocked)
                  && src_rdy(q_data[0].src2_en, q_data[0].src2, blocked);
    assign src_ok1 = src_rdy(q_data[1].src1_en, q_data[1].src1, blocked)
                  && src_rdy(q_data[1].src2_en, q_data[1].src2, blocked);

    // Only true data dependences block the younger op; equal dsts may co-issue.
    assign raw = q_data[0].dst_en && (q_data[0].dst != '0)
              && ((q_data[1].src1_en && (q_data[1].src1 == q_data[0].dst))
               || (q_data[1].src2_en && (q_data[1].src2 == q_data[0].dst)));

    assign issue[0] = !rst && !flush && (q_size != '0)
                   && src_ok0 && slot_free[0];
    assign issue[1] = issue[0] && (q_size >= IQ_ADDR'(2))
                   && slot_free[1] && src_ok1 && !raw;

    assign out_data_number = {1'b0, issue[0]} + {1'b0, issue[1]};

    // Clears first so a same-cycle newer producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k]) begin
                busy_d[wb_preg[k]] = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (issue[i] && q_data[i].dst_en && (q_data[i].dst != '0)) begin
                busy_d[q_data[i].dst] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_q      <= '0;
            iss_valid_q <= '0;
            iss_data_q  <= '0;
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < 2; i++) begin
                if (issue[i]) begin
                    iss_valid_q[i] <= 1'b1;
                    iss_data_q[i]  <= q_data[i];
                end else if (fu_ready[i]) begin
                    iss_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_data  = iss_data_q;

endmodule

// File: tb/tb_issue_select.sv
// tb_issue_select: directed scenarios plus randomized traffic checked against
// a cycle-level behavioural model of the select rules and scoreboard.
module tb_issue_select;
    import issue_select_pkg::*;

    logic                       clk;
    logic                       rst;
    logic                       flush;
    logic [IQ_ADDR-1:0]         q_size;
    issue_queue_element_t [1:0] q_data;
    logic [1:0]                 out_data_number;
    logic [1:0]                 wb_valid;
    logic [1:0][5:0]            wb_preg;
    logic [1:0]                 fu_ready;
    logic [1:0]                 iss_valid;
    issue_queue_element_t [1:0] iss_data;

    int checks   = 0;
    int failures = 0;

    bit                         mbusy [64];
    logic [1:0]                 mval;
    issue_queue_element_t [1:0] mdat;

    issue_select #(.PREG_W(6), .NUM_WB(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .q_size          (q_size),
        .q_data          (q_data),
        .out_data_number (out_data_number),
        .wb_valid        (wb_valid),
        .wb_preg         (wb_preg),
        .fu_ready        (fu_ready),
        .iss_valid       (iss_valid),
        .iss_data        (iss_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic issue_queue_element_t mk(
        input int tag, input int s1, input bit s1e,
        input int s2, input bit s2e, input int d, input bit de
    );
        issue_queue_element_t e;
        e.tag     = 8'(tag);
        e.src1    = 6'(s1);
        e.src1_en = s1e;
        e.src2    = 6'(s2);
        e.src2_en = s2e;
        e.dst     = 6'(d);
        e.dst_en  = de;
        return e;
    endfunction

    function automatic logic [63:0] exp_busy();
        logic [63:0] v;
        for (int p = 0; p < 64; p++) v[p] = mbusy[p];
        return v;
    endfunction

    function automatic bit rdy(input bit en, input logic [5:0] p);
        if (!en || p == 0) return 1'b1;
        if (!mbusy[p]) return 1'b1;
`ifdef ISSUE_WB_BYPASS_EN
        for (int k = 0; k < 2; k++)
            if (wb_valid[k] && wb_preg[k] == p) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // How many head entries may go this cycle, from the current model state.
    function automatic int exp_num();
        bit ok0, ok1, dep;
        if (rst || flush) return 0;
        ok0 = (q_size >= 1) && rdy(q_data[0].src1_en, q_data[0].src1)
           && rdy(q_data[0].src2_en, q_data[0].src2)
           && (!mval[0] || fu_ready[0]);
        if (!ok0) return 0;
        dep = q_data[0].dst_en && q_data[0].dst != 0
           && ((q_data[1].src1_en && q_data[1].src1 == q_data[0].dst)
            || (q_data[1].src2_en && q_data[1].src2 == q_data[0].dst));
        ok1 = (q_size >= 2) && rdy(q_data[1].src1_en, q_data[1].src1)
           && rdy(q_data[1].src2_en, q_data[1].src2)
           && (!mval[1] || fu_ready[1]) && !dep;
        return ok1 ? 2 : 1;
    endfunction

    task automatic tick();
        int n;
        n = exp_num();
        @(posedge clk);
        if (rst || flush) begin
            for (int p = 0; p < 64; p++) mbusy[p] = 1'b0;
            mval = 2'b00;
            mdat = '0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (wb_valid[k]) mbusy[wb_preg[k]] = 1'b0;
            for (int i = 0; i < n; i++)
                if (q_data[i].dst_en && q_data[i].dst != 0)
                    mbusy[q_data[i].dst] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (i < n) begin
                    mval[i] = 1'b1;
                    mdat[i] = q_data[i];
                end else if (fu_ready[i]) begin
                    mval[i] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; q_size = 3; fu_ready = 2'b11;
        wb_valid = 2'b00; wb_preg = '0;
        q_data[0] = mk(1, 0, 0, 0, 0, 5, 1);
        q_data[1] = mk(2, 0, 0, 0, 0, 6, 1);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (out_data_number !== 2'd0) begin
                failures++;
                $display("FAIL reset_num: got %0d want 0", out_data_number);
            end
            tick();
            checks++;
            if (iss_valid !== 2'b00) begin
                failures++;
                $display("FAIL reset_valid: got %b want 00", iss_valid);
            end
        end
        rst = 1'b0;
        q_size = 0;
        checks++;
        if (dut.busy_q !== 64'd0) begin
            failures++;
            $display("FAIL reset_busy: got %h want 0", dut.busy_q);
        end
    endtask

    task automatic test_indep_pair();
        issue_queue_element_t e0, e1;
        e0 = mk(8'h11, 0, 0, 0, 0, 5, 1);
        e1 = mk(8'h12, 7, 1, 0, 0, 6, 1);
        q_size = 2; q_data[0] = e0; q_data[1] = e1; fu_ready = 2'b11;
        #1;
        checks++;
        if (out_data_number !== 2'd2) begin
            failures++;
            $display("FAIL pair_num: got %0d want 2", out_data_number);
        end
        tick();
        checks++;
        if (iss_valid !== 2'b11 || iss_data[0] !== e0 || iss_data[1] !== e1) begin
            failures++;
            $display("FAIL pair_regs: got v=%b d0=%h d1=%h want v=11 d0=%h d1=%h",
                     iss_valid, iss_data[0], iss_data[1], e0, e1);
        end
        checks++;
        if (dut.busy_q[5] !== 1'b1 || dut.busy_q !== exp_busy()) begin
            failures++;
            $display("FAIL pair_busy: got %h want %h", dut.busy_q, exp_busy());
        end
        q_size = 0;
    endtask

    task automatic test_raw();
        issue_queue_element_t e0, e1;
        e0 = mk(8'h21, 0, 0, 0, 0, 9, 1);
        e1 = mk(8'h22, 9, 1, 0, 0, 10, 1);
        q_size = 2; q_data[0] = e0; q_data[1] = e1; fu_ready = 2'b11;
        #1;
        checks++;
        if (out_data_number !== 2'd1) begin
            failures++;
            $display("FAIL raw_num: got %0d want 1", out_data_number);
        end
        tick();
        q_size = 1; q_data[0] = e1; q_data[1] = '0;
        #1;
        checks++;
        if (out_data_number !== 2'd0) begin
            failures++;
            $display("FAIL raw_stall: got %0d want 0", out_data_number);
        end
        tick();
        wb_valid = 2'b01; wb_preg[0] = 6'd9;
        #1;
        checks++;
`ifdef ISSUE_WB_BYPASS_EN
        if (out_data_number !== 2'd1) begin
            failures++;
            $display("FAIL raw_wb_cycle: got %0d want 1", out_data_number);
        end
        tick();
        wb_valid = 2'b00; q_size = 0;
`else
        if (out_data_number !== 2'd0) begin
            failures++;
            $display("FAIL raw_wb_cycle: got %0d want 0", out_data_number);
        end
        tick();
        wb_valid = 2'b00;
        #1;
        checks++;
        if (out_data_number !== 2'd1) begin
            failures++;
            $display("FAIL raw_after_wb: got %0d want 1", out_data_number);
        end
        tick();
        q_size = 0;
`endif
        checks++;
        if (iss_valid[0] !== 1'b1 || iss_data[0] !== e1) begin
            failures++;
            $display("FAIL raw_issued: got v=%b d=%h want v=1 d=%h",
                     iss_valid[0], iss_data[0], e1);
        end
    endtask

    task automatic test_backpressure();
        issue_queue_element_t a, b;
        a = mk(8'h30, 0, 0, 0, 0, 0, 0);
        b = mk(8'h31, 0, 0, 0, 0, 0, 0);
        q_size = 1; q_data[0] = a; q_data[1] = '0; fu_ready = 2'b11;
        #1;
        tick();
        fu_ready = 2'b00; q_data[0] = b;
        #1;
        checks++;
        if (out_data_number !== 2'd0) begin
            failures++;
            $display("FAIL bp_num: got %0d want 0", out_data_number);
        end
        tick();
        checks++;
        if (iss_valid[0] !== 1'b1 || iss_data[0] !== a) begin
            failures++;
            $display("FAIL bp_hold: got v=%b d=%h want v=1 d=%h",
                     iss_valid[0], iss_data[0], a);
        end
        fu_ready = 2'b01;
        #1;
        checks++;
        if (out_data_number !== 2'd1) begin
            failures++;
            $display("FAIL bp_release: got %0d want 1", out_data_number);
        end
        tick();
        checks++;
        if (iss_data[0] !== b) begin
            failures++;
            $display("FAIL bp_next: got %h want %h", iss_data[0], b);
        end
        q_size = 0;
    endtask

    task automatic test_collision();
        q_size = 1; q_data[0] = mk(8'h40, 0, 0, 0, 0, 12, 1); fu_ready = 2'b11;
        wb_valid = 2'b01; wb_preg[0] = 6'd12;
        #1;
        tick();
        checks++;
        if (dut.busy_q[12] !== 1'b1) begin
            failures++;
            $display("FAIL collide_busy12: got %b want 1", dut.busy_q[12]);
        end
        wb_valid = 2'b00; q_size = 0;
    endtask

    task automatic test_flush();
        q_size = 2; fu_ready = 2'b11;
        q_data[0] = mk(8'h50, 0, 0, 0, 0, 3, 1);
        q_data[1] = mk(8'h51, 0, 0, 0, 0, 4, 1);
        #1;
        tick();
        checks++;
        if (iss_valid !== 2'b11 || dut.busy_q[3] !== 1'b1) begin
            failures++;
            $display("FAIL flush_setup: got v=%b b3=%b want v=11 b3=1",
                     iss_valid, dut.busy_q[3]);
        end
        flush = 1'b1; fu_ready = 2'b00;
        q_data[0] = mk(8'h52, 0, 0, 0, 0, 0, 0);
        q_data[1] = mk(8'h53, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (out_data_number !== 2'd0) begin
            failures++;
            $display("FAIL flush_num: got %0d want 0", out_data_number);
        end
        tick();
        checks++;
        if (iss_valid !== 2'b00 || dut.busy_q !== 64'd0) begin
            failures++;
            $display("FAIL flush_state: got v=%b busy=%h want v=00 busy=0",
                     iss_valid, dut.busy_q);
        end
        flush = 1'b0; q_size = 0;
    endtask

    task automatic test_random();
        int en;
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 39) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            q_size   = IQ_ADDR'($urandom_range(0, 3));
            fu_ready = 2'($urandom);
            wb_valid = 2'($urandom);
            wb_preg[0] = 6'($urandom_range(0, 7));
            wb_preg[1] = 6'($urandom_range(0, 7));
            for (int i = 0; i < 2; i++) begin
                en = $urandom;
                q_data[i] = mk($urandom_range(0, 255),
                               $urandom_range(0, 7), en[0],
                               $urandom_range(0, 7), en[1],
                               $urandom_range(0, 7), en[2]);
            end
            #1;
            checks++;
            if (out_data_number !== 2'(exp_num())) begin
                failures++;
                $display("FAIL rand_num[%0d]: got %0d want %0d",
                         c, out_data_number, exp_num());
            end
            tick();
            checks++;
            if (iss_valid !== mval || iss_data !== mdat || dut.busy_q !== exp_busy()) begin
                failures++;
                $display("FAIL rand_state[%0d]: got v=%b d=%h busy=%h want v=%b d=%h busy=%h",
                         c, iss_valid, iss_data, dut.busy_q, mval, mdat, exp_busy());
            end
        end
        rst = 1'b0; flush = 1'b0; q_size = 0; wb_valid = 2'b00;
    endtask

    initial begin
        mval = 2'b00;
        mdat = '0;
        for (int p = 0; p < 64; p++) mbusy[p] = 1'b0;
        rst = 1'b1; flush = 1'b0; q_size = 0; q_data = '0;
        wb_valid = 2'b00; wb_preg = '0; fu_ready = 2'b00;
        @(posedge clk);
        #1;
        test_reset();
        test_indep_pair();
        test_raw();
        test_backpressure();
        test_collision();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
